// File: rtl/cmos_capture_data_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmos_capture_data_if : DVP sensor bus in, packed-pixel bus out
// Rev 1.0
// ----------------------------------------------------------------------------
interface cmos_capture_data_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        cmos_frame_vsync;
  logic        cmos_frame_href;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic        line_err;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
    input  line_err, err_cnt, frame_cnt
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
    output line_err, err_cnt, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cmos_capture_data.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmos_capture_data : drops settling frames, packs DVP byte pairs into RGB565
//                     pixels, flags lines of the wrong length.
// Optional statistics counters: `define CMOS_CAPTURE_STATS_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module cmos_capture_data #(
  parameter int WAIT_FRAMES  = 10,
  parameter int CMOS_H_PIXEL = 640,
  parameter int CMOS_V_PIXEL = 480
) (
  input wire                 cam_pclk,
  input wire                 rst,
  cmos_capture_data_if.slave bus
);

  localparam logic [0:0]      S_WAIT     = 1'b0;
  localparam logic [0:0]      S_RUN      = 1'b1;
  localparam int              PS_W       = (WAIT_FRAMES < 1) ? 1 : $clog2(WAIT_FRAMES + 1);
  localparam logic [PS_W-1:0] WAIT_LAST  = PS_W'(WAIT_FRAMES);
  localparam logic [11:0]     LINE_BYTES = 12'(2 * CMOS_H_PIXEL);

  logic            vsync_d0_q, vsync_d1_q;
  logic            href_d0_q, href_d1_q;
  logic [7:0]      data_d0_q;

  logic [0:0]      state_q, state_d;
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;

  logic            byte_flag_q, byte_flag_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [15:0]     word_q, word_d;
  logic            word_done_q, word_done_d;

  logic            valid_q, valid_d;
  logic [15:0]     data_q, data_d;

  logic [11:0]     byte_cnt_q, byte_cnt_d;
  logic            line_err_q, line_err_d;

  logic            pos_vsync;
  logic            neg_href;
  logic            run;

  always_comb begin
    pos_vsync = vsync_d0_q & ~vsync_d1_q;
    neg_href  = href_d1_q & ~href_d0_q;
    run       = (state_q == S_RUN);

    // Leave WAIT only on a frame start so the first forwarded frame is whole.
    state_d  = state_q;
    ps_cnt_d = ps_cnt_q;
    if ((state_q == S_WAIT) && pos_vsync) begin
      if (ps_cnt_q == WAIT_LAST) begin
        state_d = S_RUN;
      end else begin
        ps_cnt_d = ps_cnt_q + 1'b1;
      end
    end

    byte_flag_d = 1'b0;
    hi_byte_d   = hi_byte_q;
    word_d      = word_q;
    word_done_d = 1'b0;
    if (!pos_vsync && href_d0_q) begin
      byte_flag_d = ~byte_flag_q;
      if (byte_flag_q) begin
        word_d      = {hi_byte_q, data_d0_q};
        word_done_d = 1'b1;
      end else begin
        hi_byte_d = data_d0_q;
      end
    end

    valid_d = word_done_q & run;
    data_d  = (word_done_q && run) ? word_q : data_q;

    byte_cnt_d = 12'd0;
    if (href_d0_q) begin
      byte_cnt_d = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : (byte_cnt_q + 12'd1);
    end

    // byte_cnt_q still holds the finished line's total during the neg_href cycle.
    line_err_d = neg_href & run & (byte_cnt_q != LINE_BYTES);
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      vsync_d0_q  <= 1'b0;
      vsync_d1_q  <= 1'b0;
      href_d0_q   <= 1'b0;
      href_d1_q   <= 1'b0;
      data_d0_q   <= 8'd0;
      state_q     <= S_WAIT;
      ps_cnt_q    <= '0;
      byte_flag_q <= 1'b0;
      hi_byte_q   <= 8'd0;
      word_q      <= 16'd0;
      word_done_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 16'd0;
      byte_cnt_q  <= 12'd0;
      line_err_q  <= 1'b0;
    end else begin
      vsync_d0_q  <= bus.cam_vsync;
      vsync_d1_q  <= vsync_d0_q;
      href_d0_q   <= bus.cam_href;
      href_d1_q   <= href_d0_q;
      data_d0_q   <= bus.cam_data;
      state_q     <= state_d;
      ps_cnt_q    <= ps_cnt_d;
      byte_flag_q <= byte_flag_d;
      hi_byte_q   <= hi_byte_d;
      word_q      <= word_d;
      word_done_q <= word_done_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      byte_cnt_q  <= byte_cnt_d;
      line_err_q  <= line_err_d;
    end
  end

  assign bus.cmos_frame_vsync = vsync_d1_q & run;
  assign bus.cmos_frame_href  = href_d1_q & run;
  assign bus.cmos_frame_valid = valid_q;
  assign bus.cmos_frame_data  = data_q;
  assign bus.line_err         = line_err_q;

`ifdef CMOS_CAPTURE_STATS_EN
  localparam logic [15:0] V_LINES = 16'(CMOS_V_PIXEL);

  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        run_edge;
  logic        frame_mis;
  logic [15:0] line_total;
  logic [8:0]  err_sum;

  always_comb begin
    // The WAIT->RUN edge opens the first forwarded frame: counted, but not checked.
    run_edge   = pos_vsync & (run | (ps_cnt_q == WAIT_LAST));
    line_total = line_cnt_q + {15'd0, neg_href & run};
    frame_mis  = pos_vsync & run & (line_total != V_LINES);

    err_sum   = {1'b0, err_cnt_q} + {8'd0, line_err_d} + {8'd0, frame_mis};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

    frame_cnt_d = frame_cnt_q + {15'd0, run_edge};

    line_cnt_d = line_cnt_q;
    if (pos_vsync) begin
      line_cnt_d = 16'd0;
    end else if (neg_href && run && (line_cnt_q != 16'hFFFF)) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      err_cnt_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
      line_cnt_q  <= 16'd0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign bus.err_cnt   = err_cnt_q;
  assign bus.frame_cnt = frame_cnt_q;
`else
  assign bus.err_cnt   = 8'd0;
  assign bus.frame_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_data.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cmos_capture_data : frame/line level scoreboard for cmos_capture_data
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cmos_capture_data;
  localparam int WAIT   = 2;
  localparam int HPIX   = 4;
  localparam int VPIX   = 2;
  localparam int LINE_B = 2 * HPIX;

  typedef struct {
    int len;
    int words;
    int err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cmos_capture_data_if bus();

  cmos_capture_data #(
    .WAIT_FRAMES (WAIT),
    .CMOS_H_PIXEL(HPIX),
    .CMOS_V_PIXEL(VPIX)
  ) dut (
    .cam_pclk(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_fail     = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          err_pulses = 0;
  int          exp_errs   = 0;
  int          vs_count   = 0;
  bit          model_run  = 1'b0;
  vec_t        tbl[7];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmos_frame_valid) got_q.push_back(bus.cmos_frame_data);
      if (bus.line_err) err_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic gap(input int n);
    bus.cam_href = 1'b0;
    bus.cam_data = 8'd0;
    repeat (n) tick();
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    err_pulses = 0;
    exp_errs   = 0;
  endtask

  task automatic send_vsync();
    vs_count++;
    model_run = (vs_count > WAIT);
    bus.cam_vsync = 1'b1;
    tick();
    tick();
    chk("vsync_gate", 32'(bus.cmos_frame_vsync), 32'(model_run));
    tick();
    bus.cam_vsync = 1'b0;
    gap(3);
  endtask

  task automatic send_line(input int n, input bit rnd, input logic [7:0] base);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom) : (base + 8'(i));
      b.push_back(v);
      bus.cam_href = 1'b1;
      bus.cam_data = v;
      tick();
      if (i == 2) chk("href_gate", 32'(bus.cmos_frame_href), 32'(model_run));
    end
    gap(5);
    if (model_run) begin
      for (int k = 0; k + 1 < n; k += 2) exp_q.push_back({b[k], b[k+1]});
      if (n != LINE_B) exp_errs++;
    end
  endtask

  task automatic score(input string name);
    chk({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    chk({name, "_errs"}, 32'(err_pulses), 32'(exp_errs));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({name, "_word"}, 32'(got_q[k]), 32'(exp_q[k]));
    clear_sb();
  endtask

  task automatic chk_stats_zero(input string name);
`ifdef CMOS_CAPTURE_STATS_EN
    chk({name, "_stats_run"}, 32'(bus.frame_cnt != 16'd0), 32'd1);
`else
    chk({name, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    chk({name, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
`endif
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_vsync"}, 32'(bus.cmos_frame_vsync), 32'd0);
    chk({name, "_href"}, 32'(bus.cmos_frame_href), 32'd0);
    chk({name, "_valid"}, 32'(bus.cmos_frame_valid), 32'd0);
    chk({name, "_data"}, 32'(bus.cmos_frame_data), 32'd0);
    chk({name, "_line_err"}, 32'(bus.line_err), 32'd0);
    chk({name, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
    chk({name, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] t2b[8];
    tbl[0] = '{8, 4, 0};
    tbl[1] = '{7, 3, 1};
    tbl[2] = '{1, 0, 1};
    tbl[3] = '{9, 4, 1};
    tbl[4] = '{2, 1, 1};
    tbl[5] = '{10, 5, 1};
    tbl[6] = '{3, 1, 1};
    t2b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'd0;
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Settling frames, preceded by a partial frame with no vsync.
    send_line(6, 1'b0, 8'h50);
    score("pre_vsync");
    for (int f = 1; f <= 4; f++) begin
      send_vsync();
      send_line(8, 1'b0, 8'(f * 16));
      send_line(8, 1'b0, 8'(f * 16 + 8));
      chk($sformatf("t1_frame%0d_count", f), 32'(got_q.size()), (f > WAIT) ? 32'd8 : 32'd0);
      score($sformatf("t1_frame%0d", f));
    end
`ifdef CMOS_CAPTURE_STATS_EN
    chk("t1_frame_cnt", 32'(bus.frame_cnt), 32'd2);
`else
    chk_stats_zero("t1");
`endif

    // Exact latency: second byte sampled at edge N -> valid/data at N+2.
    bus.cam_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cam_data = t2b[i];
      tick();
      case (i)
        1: chk("t2_href_out", 32'(bus.cmos_frame_href), 32'd1);
        2: chk("t2_valid_n1", 32'(bus.cmos_frame_valid), 32'd0);
        3: begin
          chk("t2_valid_n2", 32'(bus.cmos_frame_valid), 32'd1);
          chk("t2_data_n2", 32'(bus.cmos_frame_data), 32'h1234);
        end
        4: begin
          chk("t2_valid_n3", 32'(bus.cmos_frame_valid), 32'd0);
          chk("t2_data_hold", 32'(bus.cmos_frame_data), 32'h1234);
        end
        5: chk("t2_data_w2", 32'(bus.cmos_frame_data), 32'h5678);
        default: ;
      endcase
    end
    gap(5);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    exp_q.push_back(16'h9ABC);
    exp_q.push_back(16'hDEF0);
    score("t2");

    // Seven-byte line: one line_err pulse one edge after neg_href.
    bus.cam_href = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.cam_data = 8'h70 + 8'(i);
      tick();
    end
    bus.cam_href = 1'b0;
    bus.cam_data = 8'd0;
    tick();
    chk("t3_line_err_e1", 32'(bus.line_err), 32'd0);
    tick();
    chk("t3_line_err_e2", 32'(bus.line_err), 32'd1);
    tick();
    chk("t3_line_err_e3", 32'(bus.line_err), 32'd0);
    gap(4);
    chk("t3_words", 32'(got_q.size()), 32'd3);
    exp_q.push_back(16'h7071);
    exp_q.push_back(16'h7273);
    exp_q.push_back(16'h7475);
    exp_errs++;
    score("t3");
`ifdef CMOS_CAPTURE_STATS_EN
    chk("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
`else
    chk_stats_zero("t3");
`endif

    for (int i = 0; i < 7; i++) begin
      send_line(tbl[i].len, 1'b0, 8'(16 * i + 8'h20));
      chk($sformatf("tbl%0d_words", i), 32'(got_q.size()), 32'(tbl[i].words));
      chk($sformatf("tbl%0d_err", i), 32'(err_pulses), 32'(tbl[i].err));
      score($sformatf("tbl%0d", i));
    end

    // vsync rises during href after an odd byte; the byte on the edge is lost.
    bus.cam_href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.cam_data = 8'hA1 + 8'(i);
      if (i == 3) bus.cam_vsync = 1'b1;
      tick();
    end
    bus.cam_href = 1'b0;
    bus.cam_data = 8'd0;
    tick();
    tick();
    bus.cam_vsync = 1'b0;
    gap(5);
    vs_count++;
    exp_q.push_back(16'hA1A2);
    exp_q.push_back(16'hA5A6);
    exp_errs++;
    score("t5");

    // Reset mid-line in RUN.
    bus.cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cam_data = 8'hC0 + 8'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    chk_all_zero("t4_rst");
    rst = 1'b0;
    gap(4);
    clear_sb();
    vs_count  = 0;
    model_run = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      send_vsync();
      send_line(8, 1'b0, 8'h80 + 8'(f * 16));
      send_line(8, 1'b0, 8'h88 + 8'(f * 16));
      chk($sformatf("t4_frame%0d_count", f), 32'(got_q.size()), (f > WAIT) ? 32'd8 : 32'd0);
      score($sformatf("t4_frame%0d", f));
    end

    // Random frames of random-length lines with random data.
    for (int f = 0; f < 10; f++) begin
      int nl;
      send_vsync();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 12), 1'b1, 8'd0);
      score($sformatf("rnd_frame%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
